// File: rtl/in_port.sv
// Switch-entry input port: synchronises board inputs, debounces Enter/Clear and
// queues the sampled switch word in a small FIFO read by the processor's IN instruction.

module in_port_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic level_sync,
    output logic level_deb,
    output logic rise_pulse
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic             level_deb_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            level_deb <= 1'b0;
        end else if (level_sync == level_deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            level_deb <= level_sync;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Registered rising-edge detect; release produces nothing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_deb_q <= 1'b0;
            rise_pulse  <= 1'b0;
        end else begin
            level_deb_q <= level_deb;
            rise_pulse  <= level_deb & ~level_deb_q;
        end
    end
endmodule

module in_port #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int ADDR_W          = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       sw,
    input  logic              btn_enter,
    input  logic              btn_clear,
    input  logic              inread,
    output logic [15:0]       inval,
    output logic              invalid,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    logic [15:0] sw_meta, sw_sync;
    logic        enter_meta, enter_sync;
    logic        clear_meta, clear_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta    <= '0;
            sw_sync    <= '0;
            enter_meta <= 1'b0;
            enter_sync <= 1'b0;
            clear_meta <= 1'b0;
            clear_sync <= 1'b0;
        end else begin
            sw_meta    <= sw;
            sw_sync    <= sw_meta;
            enter_meta <= btn_enter;
            enter_sync <= enter_meta;
            clear_meta <= btn_clear;
            clear_sync <= clear_meta;
        end
    end

    logic enter_deb, push_pulse;
    logic clear_deb, clr_pulse;

    in_port_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_enter (
        .clock      (clock),
        .reset      (reset),
        .level_sync (enter_sync),
        .level_deb  (enter_deb),
        .rise_pulse (push_pulse)
    );

    in_port_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_clear (
        .clock      (clock),
        .reset      (reset),
        .level_sync (clear_sync),
        .level_deb  (clear_deb),
        .rise_pulse (clr_pulse)
    );

    logic [15:0]       mem [FIFO_DEPTH];
    logic [ADDR_W:0]   wptr, rptr;
    logic [ADDR_W-1:0] waddr, raddr;
    logic              empty, full;
    logic              do_push, do_pop, drop;

    assign waddr = wptr[ADDR_W-1:0];
    assign raddr = rptr[ADDR_W-1:0];
    assign empty = (wptr == rptr);
    assign full  = (waddr == raddr) && (wptr[ADDR_W] != rptr[ADDR_W]);

    // Clear wins over everything; a pop frees the slot a same-cycle push needs when full.
    assign do_pop  = inread && !empty && !clr_pulse;
    assign do_push = push_pulse && !clr_pulse && (!full || do_pop);
    assign drop    = push_pulse && !clr_pulse && full && !do_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else if (clr_pulse) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wptr     <= wptr + PTR_ONE;
            if (do_pop)  rptr     <= rptr + PTR_ONE;
            if (drop)    overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[waddr] <= sw_sync;
    end

    assign invalid = !empty;
    assign count   = wptr - rptr;
    assign inval   = empty ? 16'h0000 : mem[raddr];
endmodule

// File: tb/tb_in_port.sv
// Directed bench for in_port with a short debounce window (4 cycles) and a 4-deep FIFO.

module tb_in_port;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sw = '0;
    logic        btn_enter = 1'b0;
    logic        btn_clear = 1'b0;
    logic        inread = 1'b0;
    logic [15:0] inval;
    logic        invalid;
    logic [2:0]  count;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    in_port #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16),
        .FIFO_DEPTH      (4),
        .ADDR_W          (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .inread    (inread),
        .inval     (inval),
        .invalid   (invalid),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_enter(input logic [15:0] value);
        sw = value;
        btn_enter = 1'b1;
        tick(6);
        btn_enter = 1'b0;
        tick(10);
    endtask

    task automatic pop_one;
        inread = 1'b1;
        tick(1);
        inread = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("reset_invalid", invalid, 0);
        chk("reset_count", count, 0);
        chk("reset_inval", inval, 16'h0000);
        chk("reset_overflow", overflow, 0);
        reset = 1'b0;
        tick(2);

        // Single entry and exact latency
        sw = 16'h1234;
        btn_enter = 1'b1;
        tick(7);
        chk("lat_not_early", invalid, 0);
        tick(1);
        chk("lat_invalid_at_8", invalid, 1);
        chk("single_inval", inval, 16'h1234);
        chk("single_count", count, 1);
        tick(2);
        btn_enter = 1'b0;
        tick(10);
        chk("single_held_count", count, 1);
        pop_one();
        chk("pop_invalid", invalid, 0);
        chk("pop_inval", inval, 16'h0000);
        chk("pop_count", count, 0);

        // Glitches of 3 cycles never get accepted
        for (int g = 0; g < 5; g++) begin
            sw = 16'h0F00 + 16'(g);
            btn_enter = 1'b1;
            tick(3);
            btn_enter = 1'b0;
            tick(3);
        end
        tick(6);
        chk("glitch_count", count, 0);
        chk("glitch_invalid", invalid, 0);

        // sw changes every cycle while held: the value set 5 cycles after the rise is captured
        for (int k = 0; k < 10; k++) begin
            sw = 16'hB000 + 16'(k);
            btn_enter = 1'b1;
            tick(1);
        end
        btn_enter = 1'b0;
        tick(10);
        chk("capture_count", count, 1);
        chk("capture_value", inval, 16'hB005);
        pop_one();
        chk("capture_drained", count, 0);

        // Fill and overflow
        press_enter(16'hA001);
        press_enter(16'hA002);
        press_enter(16'hA003);
        press_enter(16'hA004);
        chk("fill_count", count, 4);
        chk("fill_no_overflow", overflow, 0);
        press_enter(16'hA005);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 4);
        chk("ovf_head", inval, 16'hA001);
        chk("read0", inval, 16'hA001); pop_one();
        chk("read1", inval, 16'hA002); pop_one();
        chk("read2", inval, 16'hA003); pop_one();
        chk("read3", inval, 16'hA004); pop_one();
        chk("drain_count", count, 0);
        chk("drain_overflow_sticky", overflow, 1);
        pop_one();
        chk("empty_read_count", count, 0);
        chk("empty_read_invalid", invalid, 0);
        chk("empty_read_inval", inval, 16'h0000);
        chk("empty_read_overflow", overflow, 1);

        // Clear with 3 queued and overflow set; a coincident Enter press is discarded
        press_enter(16'hE001);
        press_enter(16'hE002);
        press_enter(16'hE003);
        chk("pre_clear_count", count, 3);
        sw = 16'hE004;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        tick(7);
        chk("clear_before_count", count, 3);
        chk("clear_before_overflow", overflow, 1);
        tick(1);
        chk("clear_count", count, 0);
        chk("clear_invalid", invalid, 0);
        chk("clear_overflow", overflow, 0);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        tick(12);
        chk("clear_no_push", count, 0);

        // Push and pop together while full
        press_enter(16'hC001);
        press_enter(16'hC002);
        press_enter(16'hC003);
        press_enter(16'hC004);
        chk("full_again_count", count, 4);
        sw = 16'hC005;
        btn_enter = 1'b1;
        tick(7);
        inread = 1'b1;
        tick(1);
        inread = 1'b0;
        chk("pushpop_count", count, 4);
        chk("pushpop_head", inval, 16'hC002);
        chk("pushpop_overflow", overflow, 0);
        btn_enter = 1'b0;
        tick(10);
        pop_one();
        chk("pushpop_r1", inval, 16'hC003); pop_one();
        chk("pushpop_r2", inval, 16'hC004); pop_one();
        chk("pushpop_tail", inval, 16'hC005); pop_one();
        chk("pushpop_drained", count, 0);

        // Async reset mid-debounce with 2 words queued
        press_enter(16'hD001);
        press_enter(16'hD002);
        chk("pre_reset_count", count, 2);
        sw = 16'hD003;
        btn_enter = 1'b1;
        tick(2);
        #2 reset = 1'b1;
        #1;
        chk("async_invalid", invalid, 0);
        chk("async_count", count, 0);
        chk("async_inval", inval, 16'h0000);
        chk("async_overflow", overflow, 0);
        tick(2);
        reset = 1'b0;
        tick(7);
        chk("post_reset_not_early", invalid, 0);
        tick(1);
        chk("post_reset_invalid", invalid, 1);
        chk("post_reset_inval", inval, 16'hD003);
        tick(4);
        btn_enter = 1'b0;
        tick(12);
        chk("post_reset_single_push", count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/in_port.md
Name: in_port

Overview:
- Input-side counterpart of the seven-segment output block: the user-to-processor path.
- Samples the 16 board switches when the user presses an Enter button and queues the words in a small FIFO.
- The processor's IN instruction reads the FIFO through a valid/read handshake.
- Debounces the Enter and Clear push-buttons; double-flop synchronises all asynchronous board inputs.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronised button level must differ from the debounced level before it is accepted (minimum 2)
CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1
FIFO_DEPTH, 4, FIFO entries; power of two
ADDR_W, 2, log2(FIFO_DEPTH)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
sw  in  16  raw board switches, asynchronous
btn_enter  in  1  raw Enter button, active-high, asynchronous
btn_clear  in  1  raw Clear button, active-high, asynchronous
inread  in  1  processor consumes head word at this edge; honoured only while invalid=1
inval  out  16  FIFO head word; 16'h0000 when empty
invalid  out  1  FIFO non-empty
count  out  ADDR_W+1  number of queued words, 0..FIFO_DEPTH
overflow  out  1  sticky: an Enter press was dropped because the FIFO was full

Behaviour:
- Reset (async, active-high) clears everything:
  - synchronisers, debounced levels, debounce counters, edge registers, FIFO pointers, count: 0
  - overflow, invalid, inval: 0
  - FIFO storage contents need not be cleared.
- Synchronisation: sw, btn_enter and btn_clear each pass through two flops. Only the synchronised values are used downstream.
- Debounce, one independent instance per button:
  - When the synchronised level equals the debounced level, counter <= 0.
  - When they differ and counter == DEBOUNCE_CYCLES-1, the debounced level takes the synchronised level and counter <= 0.
  - Otherwise counter increments.
  - Net effect: a level must differ for DEBOUNCE_CYCLES consecutive cycles to be accepted. A glitch shorter than that has no effect.
- Edge detect:
  - push_pulse is asserted for exactly one cycle, registered, the cycle after debounced Enter rises.
  - clr_pulse is generated the same way from debounced Clear.
  - Releasing a button generates nothing.
- Push: on a push_pulse cycle, the synchronised sw value of that cycle is written at the write pointer.
- Pop: on a clock edge with inread=1 and invalid=1, the read pointer advances.
- Pointers are ADDR_W+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - empty = pointers equal.
  - full = addresses equal and MSBs differ.
  - count = wptr - rptr.
- Priority within a single cycle:
  1. clr_pulse: both pointers <= 0 and overflow <= 0; any push or pop in that cycle is discarded.
  2. Push and pop together while full: both take effect, count stays FIFO_DEPTH, overflow unchanged.
  3. Push while full with no pop: word dropped, overflow <= 1, storage and pointers unchanged.
  4. inread while empty: ignored, no pointer change, no error.
  5. Push while empty with inread=1: inread is ignored, push takes effect.
- Outputs:
  - inval, invalid and count are combinational from registered pointers and storage. They update in the cycle after the push or pop edge; there are no extra pipeline stages.
  - inval is forced to 0 when empty.
- Latency, Enter raw rise to invalid=1, with Enter held steady:
  - 2 synchroniser cycles
  - + DEBOUNCE_CYCLES
  - + 1 edge-register cycle
  - + 1 write cycle
  - The press must be held through the debounce window.
- Reset mid-operation: the FIFO empties immediately, asynchronously. A button still held when reset deasserts does not generate a push: the debounced level must first be accepted high from 0, which takes a full debounce window. It then pushes once.

Test Plan (all scenarios use DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
- Single entry: sw=16'h1234, hold Enter 10 cycles. invalid rises exactly 8 cycles after the raw rise, inval=16'h1234, count=1. Pulse inread one cycle: invalid=0, inval=16'h0000, count=0.
- Glitch rejection: Enter high for 3 cycles then low, repeated 5 times. count stays 0 and no push occurs. Toggle sw during the stable hold of a real press: the value captured is the one present at the push_pulse cycle.
- Fill and overflow:
  - Push 16'hA001..16'hA004: count=4.
  - Fifth press with 16'hA005: dropped, overflow=1.
  - Four reads return A001, A002, A003, A004 in order; overflow stays 1.
  - inread on the now-empty FIFO changes nothing.
- Simultaneous push and pop while full, holding inread=1 on the push_pulse cycle: head advances, new word is appended at the tail, count stays 4, overflow stays 0.
- Clear: with 3 words queued and overflow=1, press Clear. In the cycle after clr_pulse, count=0, invalid=0 and overflow=0. A push_pulse coincident with clr_pulse is discarded.
- Async reset: assert reset mid-debounce while 2 words are queued. All outputs go to 0 immediately. Enter held through reset deassertion produces exactly one push, 8 cycles after deassertion.
